// File: rtl/jtcontra_gfx_rom.sv
// ROM fetch responder for the 007121 tile/object renderer: a 2-entry cache in
// front of a single-outstanding-read SDRAM req/ack/data_rdy handshake.
module jtcontra_gfx_rom #(
  parameter int unsigned     AW     = 18,
  parameter int unsigned     SAW    = 22,
  parameter logic [SAW-1:0]  OFFSET = '0
) (
  input  logic           clk24,
  input  logic           rst,
  input  logic           flush,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [15:0]    rom_data,
  output logic           rom_ok,
  output logic           sdram_req,
  output logic [SAW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [15:0]    data_read
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pend_addr_q, pend_addr_d;
  logic           sdram_req_q, sdram_req_d;
  logic [SAW-1:0] sdram_addr_q, sdram_addr_d;
  logic           rom_ok_q, rom_ok_d;
  logic [15:0]    rom_data_q, rom_data_d;
  logic [1:0]     valid_q, valid_d;
  logic           ptr_q, ptr_d;
  logic [AW-1:0]  tag_q  [2];
  logic [AW-1:0]  tag_d  [2];
  logic [15:0]    data_q [2];
  logic [15:0]    data_d [2];

  logic hit0, hit1, hit;

  assign hit0 = valid_q[0] & (tag_q[0] == rom_addr);
  assign hit1 = valid_q[1] & (tag_q[1] == rom_addr);
  assign hit  = rom_cs & (hit0 | hit1);

  // NOTE: every always_comb output gets its hold/default value first, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    rom_ok_d     = 1'b0;
    rom_data_d   = rom_data_q;
    valid_d      = valid_q;
    ptr_d        = ptr_q;
    tag_d        = tag_q;
    data_d       = data_q;

    if (hit) begin
      rom_ok_d   = 1'b1;
      rom_data_d = hit0 ? data_q[0] : data_q[1];
    end else if (state_q == ST_WAIT && data_rdy) begin
      // Forward the fill straight to the renderer if it is still asking for it
      rom_ok_d   = rom_cs & (rom_addr == pend_addr_q);
      rom_data_d = data_read;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit && !flush) begin
          pend_addr_d  = rom_addr;
          sdram_addr_d = OFFSET + SAW'(rom_addr);
          sdram_req_d  = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          sdram_req_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          state_d = ST_IDLE;
          if (!flush) begin
            tag_d[ptr_q]   = pend_addr_q;
            data_d[ptr_q]  = data_read;
            valid_d[ptr_q] = 1'b1;
            ptr_d          = ~ptr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      valid_d  = 2'b00;
      rom_ok_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= OFFSET;
      rom_ok_q     <= 1'b0;
      rom_data_q   <= 16'h0000;
      valid_q      <= 2'b00;
      ptr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      rom_ok_q     <= rom_ok_d;
      rom_data_q   <= rom_data_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
    end
  end

  // NOTE: tag/data storage and the pending address are not reset; the valid
  // bits and the FSM state fully qualify them, which keeps the arrays plain RAM.
  always_ff @(posedge clk24) begin
    pend_addr_q <= pend_addr_d;
    tag_q       <= tag_d;
    data_q      <= data_d;
  end

  assign rom_ok     = rom_ok_q;
  assign rom_data   = rom_data_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtcontra_gfx_rom.sv
// Self-checking bench for jtcontra_gfx_rom: scripted SDRAM controller plus a
// scoreboard queue of expected SDRAM request addresses.
module tb_jtcontra_gfx_rom;

  localparam logic [21:0] OFF = 22'h100000;

  logic        clk24 = 1'b0;
  logic        rst, flush, rom_cs, sdram_ack, data_rdy;
  logic [17:0] rom_addr;
  logic [15:0] data_read, rom_data;
  logic        rom_ok, sdram_req;
  logic [21:0] sdram_addr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] req_exp_q [$];
  logic        prev_req = 1'b0;

  jtcontra_gfx_rom #(.AW(18), .SAW(22), .OFFSET(OFF)) dut (
    .clk24      (clk24),
    .rst        (rst),
    .flush      (flush),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read)
  );

  always #5 clk24 = ~clk24;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  // Every rising sdram_req must match the oldest expected request address
  always @(negedge clk24) begin
    if (sdram_req === 1'b1 && prev_req === 1'b0) begin
      if (req_exp_q.size() == 0) check("req_unexpected", 32'(sdram_req), 32'd0);
      else                       check("req_addr", 32'(sdram_addr), 32'(req_exp_q.pop_front()));
    end
    prev_req = sdram_req;
  end

  task automatic issue(input logic [17:0] a);
    int n;
    n = 0;
    rom_cs   = 1'b1;
    rom_addr = a;
    req_exp_q.push_back(OFF + 22'(a));
    while (sdram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(sdram_req), 32'd1);
  endtask

  task automatic complete(input logic [15:0] d, input int gap);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("req_drop", 32'(sdram_req), 32'd0);
    repeat (gap) tick();
    data_read = d;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
  endtask

  task automatic fill(input logic [17:0] a, input logic [15:0] d);
    issue(a);
    complete(d, 0);
    check("fill_ok", 32'(rom_ok), 32'd1);
    check("fill_data", 32'(rom_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rom_cs = 1'b1; rom_addr = 18'h00123;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 16'h0000;

    // Reset held two cycles with a request pending
    tick(); tick();
    check("rst_ok", 32'(rom_ok), 32'd0);
    check("rst_data", 32'(rom_data), 32'd0);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'(OFF));

    // Miss on 0x123: request on the first edge after release
    rst = 1'b0;
    req_exp_q.push_back(22'h100123);
    tick();
    check("miss_req", 32'(sdram_req), 32'd1);
    check("miss_addr", 32'(sdram_addr), 32'h100123);
    tick();
    check("req_hold", 32'(sdram_req), 32'd1);
    check("wait_ok", 32'(rom_ok), 32'd0);
    complete(16'hA55A, 4);
    check("fwd_ok", 32'(rom_ok), 32'd1);
    check("fwd_data", 32'(rom_data), 32'hA55A);
    tick();
    check("hit_ok", 32'(rom_ok), 32'd1);

    // Away and back: the cached entry answers with no new request
    rom_cs = 1'b0; rom_addr = 18'h00124;
    tick();
    check("away_ok", 32'(rom_ok), 32'd0);
    rom_cs = 1'b1; rom_addr = 18'h00123;
    tick();
    check("back_ok", 32'(rom_ok), 32'd1);
    check("back_data", 32'(rom_data), 32'hA55A);
    check("back_req", 32'(sdram_req), 32'd0);

    // Both entries valid, then flush
    fill(18'h10, 16'h1111);
    tick();
    check("pre_flush_ok", 32'(rom_ok), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ok", 32'(rom_ok), 32'd0);
    fill(18'h10, 16'h1111);

    // Two-entry reuse
    fill(18'h11, 16'h2222);
    for (int i = 0; i < 8; i++) begin
      rom_addr = (i % 2 == 0) ? 18'h10 : 18'h11;
      tick();
      check("alt_ok", 32'(rom_ok), 32'd1);
      check("alt_data", 32'(rom_data), (i % 2 == 0) ? 32'h1111 : 32'h2222);
      check("alt_req", 32'(sdram_req), 32'd0);
    end

    // Third address evicts the oldest entry (0x10); 0x11 survives
    fill(18'h12, 16'h3333);
    rom_addr = 18'h11;
    tick();
    check("survivor_ok", 32'(rom_ok), 32'd1);
    check("survivor_data", 32'(rom_data), 32'h2222);
    fill(18'h10, 16'h1111);

    // Address change while waiting for data
    issue(18'h20);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rom_addr = 18'h30;
    tick();
    data_read = 16'h4444; data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    check("chg_ok", 32'(rom_ok), 32'd0);
    issue(18'h30);
    complete(16'h5555, 0);
    check("chg2_ok", 32'(rom_ok), 32'd1);
    check("chg2_data", 32'(rom_data), 32'h5555);
    rom_addr = 18'h20;
    tick();
    check("chg_cached_ok", 32'(rom_ok), 32'd1);
    check("chg_cached_data", 32'(rom_data), 32'h4444);

    // Flush on the fill edge: nothing becomes valid
    issue(18'h40);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    flush = 1'b1; data_rdy = 1'b1; data_read = 16'h6666;
    tick();
    flush = 1'b0; data_rdy = 1'b0; rom_cs = 1'b0;
    check("flush_fill_ok", 32'(rom_ok), 32'd0);
    tick();
    issue(18'h20);
    complete(16'h4444, 0);
    check("refill20_ok", 32'(rom_ok), 32'd1);
    issue(18'h40);
    complete(16'h6666, 0);
    check("refill40_data", 32'(rom_data), 32'h6666);

    // Reset during WAIT, then a stale data_rdy
    issue(18'h50);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst = 1'b1; rom_cs = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_req", 32'(sdram_req), 32'd0);
    check("mid_rst_addr", 32'(sdram_addr), 32'(OFF));
    check("mid_rst_data", 32'(rom_data), 32'd0);
    data_read = 16'h7777; data_rdy = 1'b1;
    tick();
    data_rdy = 1'b0;
    check("stale_ok", 32'(rom_ok), 32'd0);
    check("stale_req", 32'(sdram_req), 32'd0);
    issue(18'h20);
    complete(16'h4444, 0);
    issue(18'h50);
    complete(16'h7777, 0);
    check("post_rst_data", 32'(rom_data), 32'h7777);

    rom_cs = 1'b0;
    tick(); tick();
    check("req_queue_empty", 32'(req_exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtcontra_gfx_rom.md
Name: jtcontra_gfx_rom

Overview:
- SDRAM-side responder for the tile/object renderer's ROM fetch port.
- Accepts rom_cs/rom_addr word requests and answers with rom_data/rom_ok.
- Serves hits from a 2-entry cache. On a miss it issues one SDRAM read through a req/ack/data_rdy handshake.
- Sits between the 007121 graphics engine and the SDRAM controller slot, all in the clk24 domain.

Parameters:
- AW, 18, width of rom_addr (16-bit words).
- SAW, 22, width of the SDRAM word address.
- OFFSET, 22'h0, base SDRAM word address of this ROM region; width SAW.

Ports:
- clk24 input 1: clock; all logic on its rising edge.
- rst input 1: synchronous, active-high reset.
- flush input 1: invalidates both cache entries; used during ROM download.
- rom_cs input 1: renderer request, level-held until rom_ok is seen.
- rom_addr input AW: requested word address.
- rom_data output 16: data for rom_addr, valid while rom_ok=1.
- rom_ok output 1: rom_data matches the current rom_addr and rom_cs.
- sdram_req output 1: read request, held until sdram_ack.
- sdram_addr output SAW: OFFSET + zero-extended latched address.
- sdram_ack input 1: one-cycle pulse; controller accepted the request.
- data_rdy input 1: one-cycle pulse; data_read valid.
- data_read input 16: SDRAM read data.

Behaviour:
- Reset (rst=1 at an edge):
  - rom_ok=0, rom_data=0, sdram_req=0, sdram_addr=OFFSET.
  - Both valid bits cleared, replacement pointer=0, state=IDLE.
  - Reset mid-transaction abandons the transaction. Any later data_rdy arriving in IDLE is ignored.
- Cache:
  - 2 entries, each holding a valid bit, an AW-bit tag and 16-bit data.
  - hit = rom_cs & ((v0 & tag0==rom_addr) | (v1 & tag1==rom_addr)).
- rom_ok/rom_data registered every edge:
  - rom_ok <= hit, with rom_data <= the hitting entry's data (entry 0 has priority if both match).
  - Forwarding: when state=WAIT and data_rdy=1, rom_ok <= rom_cs & (rom_addr==pend_addr) and rom_data <= data_read.
  - If neither applies, rom_ok <= 0 and rom_data holds its value.
  - Latency: hit -> rom_ok on the first edge after rom_cs/rom_addr present.
  - Address change -> rom_ok drops on the next edge unless the new address hits.
- State machine IDLE/REQ/WAIT:
  - IDLE: if rom_cs & ~hit & ~flush: pend_addr <= rom_addr, sdram_addr <= OFFSET + rom_addr, sdram_req <= 1, go to REQ.
  - REQ: hold sdram_req and sdram_addr until sdram_ack=1, then sdram_req <= 0 and go to WAIT. If sdram_ack arrives on the same edge req is raised, it is not seen; ack is sampled only in REQ.
  - WAIT: on data_rdy=1, write data_read and tag pend_addr into the entry at the replacement pointer, set its valid bit, toggle the pointer, go to IDLE.
  - Minimum miss latency is 3 edges when ack and data_rdy each take one cycle.
- rom_cs dropped or rom_addr changed during REQ/WAIT:
  - The transaction completes and fills the cache with pend_addr.
  - No new request is issued until IDLE is re-entered. The new address is evaluated in IDLE.
- flush:
  - Clears both valid bits and forces rom_ok <= 0 on that edge.
  - If flush coincides with a WAIT fill, the fill is discarded: valid stays 0, the pointer is unchanged, and the state still returns to IDLE.
  - flush does not cancel an outstanding REQ; the req/ack handshake completes.
- Arithmetic: OFFSET + rom_addr is a SAW-bit add, wrapping modulo 2^SAW.
- Outputs change only on clk24 edges; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst 2 cycles with rom_cs=1 -> rom_ok=0, sdram_req=0, sdram_addr=OFFSET; after release, rom_addr=18'h00123 miss -> sdram_req=1 next edge.
- Miss then hit:
  - Stimulus: OFFSET=22'h100000, rom_addr=18'h00123; ack 2 cycles after req; data_rdy 5 cycles later with data 16'hA55A.
  - Required: sdram_addr=22'h100123; rom_ok=1 with rom_data=16'hA55A on the data_rdy edge (forwarded).
  - Then toggle rom_addr away and back -> rom_ok=1 one edge after return, with no new sdram_req.
- Two-entry reuse: fill addresses 18'h10 (16'h1111) and 18'h11 (16'h2222), then alternate each cycle -> rom_ok stays 1 with matching data and sdram_req stays 0.
- Third address 18'h12 after that fill -> evicts entry 0 (18'h10). Requesting 18'h10 again -> new sdram_req.
- Address change mid-WAIT: request 18'h20, switch rom_addr to 18'h30 before data_rdy -> rom_ok=0 on the data_rdy edge, cache holds 18'h20, and a second req for 18'h30 is issued from IDLE.
- Flush: with both entries valid, pulse flush -> rom_ok=0 next edge, and the next rom_cs on a previously cached address issues sdram_req.
- Flush coinciding with data_rdy -> no entry becomes valid.
- Reset during WAIT: raise rst, then send data_rdy -> cache stays empty and rom_ok=0.
